// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame receiver and the future transmitter:
// FSM state encoding and default frame format.
package serial_frame_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_PARITY_EN = 1;
  localparam int DEF_STOP_BITS = 1;

endpackage

// File: rtl/serial_frame_rx_hold_reg.sv
// One-entry holding register between the frame receiver and a word consumer.
// A completed word loads only when the holder is empty or being drained this edge.
module rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              overrun
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              consume;

  assign consume = valid_q & data_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      if (!valid_q || consume) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        // holder still owned by the consumer: keep the old word, drop the new one
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W data bits LSB first, optional even
// parity, STOP_BITS stop bits; good words go to a valid/ready holding register.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PARITY_EN = DEF_PARITY_EN,
  parameter int STOP_BITS = DEF_STOP_BITS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              bit_en,
  input  logic              sdi,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int              CNT_W     = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              stop_bad_q, stop_bad_d;
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              word_done;
  logic              last_data, last_stop, stop_bad_now;

  assign last_data    = (bit_cnt_q == LAST_BIT);
  assign last_stop    = (stop_cnt_q == STOP_LAST);
  assign stop_bad_now = stop_bad_q | ~sdi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        IDLE:    if (!sdi) state_d = DATA;
        DATA:    if (last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_d = STOP;
        STOP:    if (last_stop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift register, bit/stop counters and accumulated check results
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    stop_cnt_d = stop_cnt_q;
    stop_bad_d = stop_bad_q;
    par_bad_d  = par_bad_q;
    if (bit_en) begin
      case (state_q)
        IDLE: if (!sdi) begin
          bit_cnt_d = '0;
          shift_d   = '0;
          par_bad_d = 1'b0;
        end
        DATA: begin
          // right shift lands the first-received bit in the LSB after DATA_W bits
          shift_d   = {sdi, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_data) begin
            stop_cnt_d = 1'b0;
            stop_bad_d = 1'b0;
          end
        end
        PARITY: par_bad_d = (^shift_q) ^ sdi;
        STOP: if (!last_stop) begin
          stop_cnt_d = 1'b1;
          stop_bad_d = stop_bad_now;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = (state_q != IDLE);
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    word_done    = 1'b0;
    if (bit_en && state_q == STOP && last_stop) begin
      frame_err_d  = stop_bad_now;
      parity_err_d = ~stop_bad_now & par_bad_q;
      word_done    = ~stop_bad_now & ~par_bad_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      stop_cnt_q   <= 1'b0;
      stop_bad_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      stop_cnt_q   <= stop_cnt_d;
      stop_bad_q   <= stop_bad_d;
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

  rx_hold_reg #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk       (clk),
    .rstn      (rstn),
    .load      (word_done),
    .load_data (shift_q),
    .data_ready(data_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (defaults: 8 data bits, even parity, 1 stop)
// with a frame-level reference model compared on every falling edge.
module tb_serial_frame_rx;

  logic       clk;
  logic       rstn;
  logic       bit_en;
  logic       sdi;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;
  logic chk_on = 1'b0;

  serial_frame_rx dut (
    .clk       (clk),
    .rstn      (rstn),
    .bit_en    (bit_en),
    .sdi       (sdi),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gather the 10 strobed bits after a start bit, then judge
  // the whole frame by counting ones and looking at the stop bit.
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  logic       m_busy  = 1'b0;
  int         m_n     = 0;
  logic       m_bits [0:8];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_perr  <= 1'b0;
      m_ferr  <= 1'b0;
      m_ovr   <= 1'b0;
      m_busy  <= 1'b0;
      m_n     <= 0;
    end else begin
      automatic logic       ld   = 1'b0;
      automatic logic [7:0] w    = 8'h00;
      automatic int         ones = 0;
      m_perr <= 1'b0;
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      if (bit_en) begin
        if (!m_busy) begin
          if (!sdi) begin
            m_busy <= 1'b1;
            m_n    <= 0;
          end
        end else if (m_n < 9) begin
          m_bits[m_n] <= sdi;
          m_n         <= m_n + 1;
        end else begin
          for (int i = 0; i < 8; i++) begin
            w[i] = m_bits[i];
            ones += int'(m_bits[i]);
          end
          ones += int'(m_bits[8]);
          m_busy <= 1'b0;
          if (!sdi)            m_ferr <= 1'b1;
          else if (ones % 2)   m_perr <= 1'b1;
          else                 ld = 1'b1;
        end
      end
      if (ld) begin
        if (!m_valid || data_ready) begin
          m_valid <= 1'b1;
          m_data  <= w;
        end else begin
          m_ovr <= 1'b1;
        end
      end else if (m_valid && data_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("data_out",   32'(data_out),   32'(m_data));
      chk("data_valid", 32'(data_valid), 32'(m_valid));
      chk("parity_err", 32'(parity_err), 32'(m_perr));
      chk("frame_err",  32'(frame_err),  32'(m_ferr));
      chk("overrun",    32'(overrun),    32'(m_ovr));
      chk("busy",       32'(busy),       32'(m_busy));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bit_en     = 1'b0;
      sdi        = 1'b1;
      data_ready = 1'b0;
    end
  endtask

  // Drives one frame; gap idle cycles (with toggling sdi) follow every bit but the last.
  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stopv,
                            input int gap, input logic rdy_last, input logic with_start);
    logic b [0:10];
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[i+1] = d[i];
    b[9]  = (^d) ^ pflip;
    b[10] = stopv;
    for (int k = (with_start ? 0 : 1); k < 11; k++) begin
      @(negedge clk);
      bit_en     = 1'b1;
      sdi        = b[k];
      data_ready = (k == 10) ? rdy_last : 1'b0;
      if (k < 10) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bit_en = 1'b0;
          sdi    = ~sdi;
        end
      end
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bit_en     = 1'b0;
    sdi        = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    rstn       = 1'b1;
    bit_en     = 1'b0;
    sdi        = 1'b1;
    data_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rst data_out",   32'(data_out),   32'h0);
    chk("rst data_valid", 32'(data_valid), 32'h0);
    chk("rst busy",       32'(busy),       32'h0);
    chk("rst errs",       32'({parity_err, frame_err, overrun}), 32'h0);
    repeat (3) @(negedge clk);
    rstn   = 1'b1;
    chk_on = 1'b1;
    idle(2);

    // Good 0xA5 frame, parity bit 0
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(1);
    chk("A5 data_out",   32'(data_out),   32'hA5);
    chk("A5 data_valid", 32'(data_valid), 32'h1);
    chk("A5 errs",       32'({parity_err, frame_err, overrun}), 32'h0);
    consume();
    chk("A5 consumed",   32'(data_valid), 32'h0);

    // Same frame with a wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    idle(1);
    chk("par parity_err", 32'(parity_err), 32'h1);
    chk("par data_valid", 32'(data_valid), 32'h0);
    idle(1);
    chk("par pulse end",  32'(parity_err), 32'h0);
    chk("par busy",       32'(busy),       32'h0);

    // Stop bit 0, then a good frame starting on the very next strobe
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    @(negedge clk);
    bit_en = 1'b1;
    sdi    = 1'b0;
    chk("fe frame_err",  32'(frame_err),  32'h1);
    chk("fe data_valid", 32'(data_valid), 32'h0);
    send_frame(8'h12, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle(1);
    chk("12 data_out",   32'(data_out),   32'h12);
    chk("12 data_valid", 32'(data_valid), 32'h1);
    consume();

    // Overrun: two good words back-to-back, nobody reading
    send_frame(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(1);
    chk("ovr overrun",  32'(overrun),  32'h1);
    chk("ovr data_out", 32'(data_out), 32'h11);
    // Consumer drains on the completion edge: new word takes the slot
    send_frame(8'h22, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    idle(1);
    chk("ovr2 overrun",  32'(overrun),    32'h0);
    chk("ovr2 data_out", 32'(data_out),   32'h22);
    chk("ovr2 valid",    32'(data_valid), 32'h1);
    consume();

    // Sparse strobes over an idle line, then a sparse frame with noisy gaps
    for (int s = 0; s < 20; s++) begin
      @(negedge clk);
      bit_en = 1'b1;
      sdi    = 1'b1;
      idle(3);
    end
    chk("sparse busy", 32'(busy), 32'h0);
    send_frame(8'h81, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    idle(1);
    chk("81 data_out", 32'(data_out), 32'h81);

    // Reset during the data bits of 0x5A while 0x81 is still held
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(1);
    consume();
    send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    @(negedge clk);
    bit_en = 1'b1;
    sdi    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sdi = (8'h5A >> i) & 8'h1;
    end
    #2 rstn = 1'b0;
    #1;
    chk("mid rst data_out",   32'(data_out),   32'h0);
    chk("mid rst data_valid", 32'(data_valid), 32'h0);
    chk("mid rst busy",       32'(busy),       32'h0);
    chk("mid rst errs",       32'({parity_err, frame_err, overrun}), 32'h0);
    @(negedge clk);
    bit_en = 1'b0;
    sdi    = 1'b1;
    rstn   = 1'b1;
    idle(2);
    send_frame(8'h5A, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    idle(1);
    chk("5A data_out",   32'(data_out),   32'h5A);
    chk("5A data_valid", 32'(data_valid), 32'h1);
    chk("5A errs",       32'({parity_err, frame_err, overrun}), 32'h0);
    idle(3);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
